seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter N_DIG, default 4, number of multiplexed 7-segment digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, clocks each digit is driven (>=2).
REQ-003 SHALL have parameter GUARD, default 500, all-dark clocks between digits (>=1).
REQ-004 SHALL have port iCLK  input  1  single system clock, rising edge.
REQ-005 SHALL have port iRST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iLOAD  input  1  one-clock strobe capturing iDATA.
REQ-007 SHALL have port iDATA  input  4*N_DIG  BCD digits, digit k at bits [4k+3:4k], digit 0 least significant.
REQ-008 SHALL have port iBLANK_LZ  input  1  leading-zero blanking enable.
REQ-009 SHALL have port oSEG  output  7  segments, active-low, bit 6 = g .. bit 0 = a.
REQ-010 SHALL have port oDIG_N  output  N_DIG  digit enables, active-low, at most one low.
REQ-011 SHALL have port oFRAME  output  1  one-clock pulse at frame wrap.

Function
REQ-012 SHALL hold a shadow register, an active register (both 4*N_DIG), a pending flag, a digit index, a phase counter and a two-state FSM {DARK, ON}.
REQ-013 SHALL, when iLOAD=1, write iDATA to shadow and set pending; multiple loads within a frame: last wins.
REQ-014 SHALL stay in DARK exactly GUARD clocks with oDIG_N all 1 and oSEG=7'h7F.
REQ-015 SHALL go DARK->ON after GUARD clocks, driving oDIG_N[index]=0 and oSEG=decode of active digit[index] for exactly DIV clocks.
REQ-016 SHALL go ON->DARK after DIV clocks, incrementing index, wrapping N_DIG-1 -> 0; frame period = N_DIG*(GUARD+DIV) clocks.
REQ-017 SHALL register oSEG/oDIG_N so they change on the same edge the FSM enters a state; no combinational path from iDATA to outputs.
REQ-018 SHALL decode 0..9 to 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000; values 10..15 SHALL give 7'h7F (never X).
REQ-019 SHALL, with iBLANK_LZ=1, output 7'h7F for digit k>0 when digit k and all more significant digits are 0; digit 0 always shown.
REQ-020 SHALL, on the ON->DARK edge where index wraps to 0, pulse oFRAME for one clock and, if pending, copy shadow to active and clear pending.
REQ-021 SHALL, for iLOAD on that same wrap edge, copy the previous shadow to active, write new iDATA to shadow and leave pending=1.
REQ-022 SHALL never change active except at frame wrap (no tearing mid-frame).

Reset
REQ-023 SHALL, while iRST_N=0, immediately force oSEG=7'h7F, oDIG_N all 1, oFRAME=0, FSM=DARK, index=0, counter=0, shadow=active=0, pending=0.
REQ-024 SHALL, after release, start with a full GUARD period for digit 0; reset mid-ON SHALL abort the digit with no partial-pulse after release.

Structure
REQ-025 SHALL place the decode table constants, blank code 7'h7F and the FSM state encoding in a shared package seg7_pkg.
REQ-026 SHALL instantiate exactly one shared decoder sub-module, seg7_dec (4-bit BCD in, 7-bit active-low out, 7'h7F for invalid), time-shared across digits.
REQ-027 SHALL size the phase counter $clog2(max(DIV,GUARD)) bits and the index $clog2(N_DIG) bits (min 1).

Verification (N_DIG=4, DIV=4, GUARD=1, 20-clock frame)
REQ-028 SHALL check timing: each oDIG_N bit low exactly 4 clocks, 1 all-high clock between, order 0,1,2,3, oFRAME every 20 clocks.
REQ-029 SHALL check load 16'h1234 mid-frame -> unchanged until oFRAME; next frame digit0=0011001, digit1=0110000, digit2=0100100, digit3=1111001.
REQ-030 SHALL check 16'h0070, iBLANK_LZ=1 -> digits 3,2 = 7'h7F, digit1=1111000, digit0=1000000; iBLANK_LZ=0 -> digits 3,2 = 1000000.
REQ-031 SHALL check digit value 4'hA -> that digit shows 7'h7F.
REQ-032 SHALL check iLOAD coincident with oFRAME edge -> that frame shows the previous shadow, new value appears one frame later.
REQ-033 SHALL check iRST_N low mid-ON -> oSEG=7'h7F, oDIG_N=4'hF without waiting for a clock edge; restart at digit 0 after 1 dark clock.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: segment codes and scan FSM encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit 6 = g .. bit 0 = a; entry d is the code for digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    ST_DARK = 1'b0,
    ST_ON   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_dec.sv
// BCD to active-low 7-segment decoder; codes 10..15 come out fully dark.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner with a dark guard gap between digits and
// frame-synchronous double-buffered display data.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_DARK | all digits off for GUARD clocks before the next digit
//   ST_ON   | digit idx driven for DIV clocks
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iLOAD,
  input  logic [4*N_DIG-1:0] iDATA,
  input  logic               iBLANK_LZ,
  output logic [6:0]         oSEG,
  output logic [N_DIG-1:0]   oDIG_N,
  output logic               oFRAME
);

  localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] DIV_TC   = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  scan_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               wrap;
  logic               enter_on, enter_dark;

  logic [4*N_DIG-1:0] shadow, active;
  logic               pending;

  logic [3:0]         digit_cur;
  logic               upper_zero, lz_blank;
  logic [6:0]         seg_dec;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_DARK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    wrap      = 1'b0;
    case (state)
      ST_DARK: begin
        if (cnt == GUARD_TC) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end
      end
      ST_ON: begin
        if (cnt == DIV_TC) begin
          state_nxt = ST_DARK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
    endcase
  end

  assign enter_on   = (state == ST_DARK) && (state_nxt == ST_ON);
  assign enter_dark = (state == ST_ON) && (state_nxt == ST_DARK);

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    digit_cur  = '0;
    upper_zero = 1'b1;
    for (int k = 0; k < N_DIG; k++) begin
      if (IDX_W'(k) == idx) digit_cur = active[4*k +: 4];
      if ((k >= int'(idx)) && (active[4*k +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    lz_blank = iBLANK_LZ && (idx != '0) && upper_zero;
  end

  seg7_dec u_dec (
    .bcd (digit_cur),
    .seg (seg_dec)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSEG   <= SEG_BLANK;
      oDIG_N <= '1;
      oFRAME <= 1'b0;
    end else begin
      oFRAME <= wrap;
      if (enter_on) begin
        oSEG   <= lz_blank ? SEG_BLANK : seg_dec;
        oDIG_N <= ~(N_DIG'(1) << idx);
      end else if (enter_dark) begin
        oSEG   <= SEG_BLANK;
        oDIG_N <= '1;
      end
    end
  end

  // Active only moves at the frame wrap; a load on that same edge stays pending.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (iLOAD) shadow <= iDATA;
      if (wrap && pending) active <= shadow;
      if (iLOAD) pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with N_DIG=4, DIV=4, GUARD=1 (20-clock frame).
module tb_seg7_scan;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iLOAD;
  logic [15:0] iDATA;
  logic        iBLANK_LZ;
  logic [6:0]  oSEG;
  logic [3:0]  oDIG_N;
  logic        oFRAME;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] sb[$];

  typedef struct {
    logic [15:0]     data;
    logic            blank;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs[8];

  seg7_scan #(.N_DIG(4), .DIV(4), .GUARD(1)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iLOAD     (iLOAD),
    .iDATA     (iDATA),
    .iBLANK_LZ (iBLANK_LZ),
    .oSEG      (oSEG),
    .oDIG_N    (oDIG_N),
    .oFRAME    (oFRAME)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0][6:0] s);
    for (int k = 0; k < 4; k++) sb.push_back(s[k]);
  endtask

  // Entered at the negedge showing the oFRAME pulse; leaves at the next one.
  task automatic run_frame(input int pa, input logic [15:0] da,
                           input int pb, input logic [15:0] db, input logic bl);
    logic [6:0] exp_seg;
    logic [3:0] exp_dn;
    logic       on;
    exp_seg = 7'h7F;
    for (int p = 0; p < 20; p++) begin
      on = 1'b0;
      exp_dn = 4'hF;
      if (p > 0 && ((p - 1) % 5) < 4) begin
        on = 1'b1;
        exp_dn = ~(4'b0001 << ((p - 1) / 5));
      end
      chk("dig_n", 32'(oDIG_N), 32'(exp_dn));
      chk("frame", 32'(oFRAME), (p == 0) ? 32'd1 : 32'd0);
      if (on && ((p - 1) % 5) == 0) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard: empty at %0t", $time);
        end else begin
          exp_seg = sb.pop_front();
        end
      end
      chk(on ? "seg_on" : "seg_dark", 32'(oSEG), on ? 32'(exp_seg) : 32'h7F);
      iLOAD = (p == pa) || (p == pb);
      if (p == pb) iDATA = db;
      else if (p == pa) iDATA = da;
      if (p == 19) iBLANK_LZ = bl;
      @(negedge iCLK);
    end
    iLOAD = 1'b0;
  endtask

  initial begin
    int waited;
    vecs[0] = '{16'h1234, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{16'h0070, 1'b1, {7'h7F,      7'h7F,      7'b1111000, 7'b1000000}};
    vecs[2] = '{16'h0070, 1'b0, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}};
    vecs[3] = '{16'h00A5, 1'b0, {7'b1000000, 7'b1000000, 7'h7F,      7'b0010010}};
    vecs[4] = '{16'h0000, 1'b1, {7'h7F,      7'h7F,      7'h7F,      7'b1000000}};
    vecs[5] = '{16'h9876, 1'b0, {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}};
    vecs[6] = '{16'h0F08, 1'b1, {7'h7F,      7'h7F,      7'b1000000, 7'b0000000}};
    vecs[7] = '{16'hB0C1, 1'b1, {7'h7F,      7'b1000000, 7'h7F,      7'b1111001}};

    iRST_N = 1'b0;
    iLOAD = 1'b0;
    iDATA = 16'h0;
    iBLANK_LZ = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rst_seg", 32'(oSEG), 32'h7F);
    chk("rst_dig_n", 32'(oDIG_N), 32'hF);
    chk("rst_frame", 32'(oFRAME), 32'd0);

    iRST_N = 1'b1;
    #1;
    chk("rel_dig_n", 32'(oDIG_N), 32'hF);
    @(negedge iCLK);
    chk("first_dig_n", 32'(oDIG_N), 32'hE);
    chk("first_seg", 32'(oSEG), 32'(7'b1000000));

    waited = 0;
    while (oFRAME !== 1'b1 && waited < 60) begin
      @(negedge iCLK);
      waited++;
    end
    chk("frame_sync", 32'(oFRAME), 32'd1);

    // Each frame loads the next vector mid-frame while showing the previous one.
    push_exp({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
    for (int i = 0; i < 8; i++) begin
      run_frame(7, vecs[i].data, -1, 16'h0, vecs[i].blank);
      push_exp(vecs[i].segs);
    end

    // Two loads in one frame: the later one is shown.
    run_frame(3, 16'h5555, 12, 16'h2468, 1'b0);
    push_exp({7'b0100100, 7'b0011001, 7'b0000010, 7'b0000000});

    // Load on the wrap edge: previous shadow shows first, the new value a frame later.
    run_frame(7, 16'h1357, 19, 16'h8642, 1'b0);
    push_exp({7'b1111001, 7'b0110000, 7'b0010010, 7'b1111000});
    run_frame(-1, 16'h0, -1, 16'h0, 1'b0);
    push_exp({7'b0000000, 7'b0000010, 7'b0011001, 7'b0100100});
    run_frame(-1, 16'h0, -1, 16'h0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of digit 0's on-time.
    repeat (2) @(negedge iCLK);
    chk("pre_rst_dig_n", 32'(oDIG_N), 32'hE);
    iRST_N = 1'b0;
    #1;
    chk("async_seg", 32'(oSEG), 32'h7F);
    chk("async_dig_n", 32'(oDIG_N), 32'hF);
    chk("async_frame", 32'(oFRAME), 32'd0);
    repeat (2) @(negedge iCLK);
    chk("held_dig_n", 32'(oDIG_N), 32'hF);
    iRST_N = 1'b1;
    #1;
    chk("rel2_dig_n", 32'(oDIG_N), 32'hF);
    @(negedge iCLK);
    chk("restart_seg", 32'(oSEG), 32'(7'b1000000));
    for (int c = 0; c < 4; c++) begin
      chk("restart_dig_n", 32'(oDIG_N), 32'hE);
      @(negedge iCLK);
    end
    chk("restart_gap", 32'(oDIG_N), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
